// File: rtl/traffic_ctrl.sv
// traffic_ctrl: two-road traffic-light sequencer running from the 1 kHz
// scanner clock. Produces lamp drives for main (M) and side (S) roads and the
// per-road countdowns split into decimal digits for the 6-digit display.
module traffic_ctrl #(
  parameter int TICK_DIV = 1000,
  parameter int T_MG     = 30,
  parameter int T_SG     = 20,
  parameter int T_Y      = 3
) (
  input  logic       CLK1K,
  input  logic       rst_n,
  input  logic       hold,
  input  logic       night,
  output logic [2:0] lamp_m,
  output logic [2:0] lamp_s,
  output logic [3:0] num_1,
  output logic [3:0] num_2,
  output logic [3:0] num_3,
  output logic [3:0] num_4,
  output logic [3:0] num_5,
  output logic [3:0] num_6
);

  localparam int            CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [6:0]    DUR_MG   = 7'(T_MG);
  localparam logic [6:0]    DUR_SG   = 7'(T_SG);
  localparam logic [6:0]    DUR_Y    = 7'(T_Y);
  localparam logic [3:0]    BLANK    = 4'hA;
  localparam logic [2:0]    LAMP_R   = 3'b100;
  localparam logic [2:0]    LAMP_Y   = 3'b010;
  localparam logic [2:0]    LAMP_G   = 3'b001;

  typedef enum logic [2:0] {
    ST_MG    = 3'd0,
    ST_MY    = 3'd1,
    ST_SG    = 3'd2,
    ST_SY    = 3'd3,
    ST_NIGHT = 3'd4
  } state_t;

  typedef struct packed {
    logic [2:0] lm;
    logic [2:0] ls;
    logic [3:0] n1;
    logic [3:0] n2;
    logic [3:0] n3;
    logic [3:0] n4;
    logic [3:0] n6;
  } disp_t;

  state_t        state_r, state_nx;
  logic [6:0]    rem_r, rem_nx;
  logic [CW-1:0] cnt_r, cnt_nx;
  logic          flash_r, flash_nx;
  disp_t         disp_r;
  logic          tick_s;

  // Split a 0..99 value into {tens, ones}; a zero tens digit stays 0.
  function automatic logic [7:0] split_dec(input logic [6:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 7'd10);
    ones = 4'(v % 7'd10);
    return {tens, ones};
  endfunction

  // Phase duration loaded on entry to a phase.
  function automatic logic [6:0] phase_dur(input state_t st);
    case (st)
      ST_MG:   return DUR_MG;
      ST_MY:   return DUR_Y;
      ST_SG:   return DUR_SG;
      ST_SY:   return DUR_Y;
      default: return DUR_MG;
    endcase
  endfunction

  // Fixed day-cycle order; anything unexpected restarts at main green.
  function automatic state_t next_phase(input state_t st);
    case (st)
      ST_MG:   return ST_MY;
      ST_MY:   return ST_SG;
      ST_SG:   return ST_SY;
      ST_SY:   return ST_MG;
      default: return ST_MG;
    endcase
  endfunction

  // Display/lamp decode. The red road counts down to its own green, which is
  // the current phase remainder plus the following yellow when in green.
  function automatic disp_t decode(input state_t st, input logic [6:0] rem,
                                   input logic flash);
    disp_t      d;
    logic [6:0] main_v;
    logic [6:0] side_v;
    logic [7:0] md;
    logic [7:0] sd;
    d      = {$bits(disp_t){1'b0}};
    main_v = rem;
    side_v = rem;
    case (st)
      ST_MG: begin d.lm = LAMP_G; d.ls = LAMP_R; side_v = rem + DUR_Y; d.n6 = 4'd1; end
      ST_MY: begin d.lm = LAMP_Y; d.ls = LAMP_R; d.n6 = 4'd2; end
      ST_SG: begin d.lm = LAMP_R; d.ls = LAMP_G; main_v = rem + DUR_Y; d.n6 = 4'd3; end
      ST_SY: begin d.lm = LAMP_R; d.ls = LAMP_Y; d.n6 = 4'd4; end
      default: begin
        d.lm = {1'b0, flash, 1'b0};
        d.ls = {1'b0, flash, 1'b0};
        d.n6 = BLANK;
      end
    endcase
    md = split_dec(main_v);
    sd = split_dec(side_v);
    if (st == ST_NIGHT) begin
      d.n1 = BLANK; d.n2 = BLANK; d.n3 = BLANK; d.n4 = BLANK;
    end else begin
      d.n1 = md[3:0]; d.n2 = md[7:4]; d.n3 = sd[3:0]; d.n4 = sd[7:4];
    end
    return d;
  endfunction

  assign tick_s = (cnt_r == CNT_MAX);

  // Next-state: night overrides everything, hold freezes divider and timer.
  always_comb begin
    state_nx = state_r;
    rem_nx   = rem_r;
    cnt_nx   = cnt_r;
    flash_nx = flash_r;
    if (night) begin
      if (state_r != ST_NIGHT) begin
        state_nx = ST_NIGHT;
        cnt_nx   = CNT_ZERO;
        flash_nx = 1'b0;
      end else if (tick_s) begin
        cnt_nx   = CNT_ZERO;
        flash_nx = ~flash_r;
      end else begin
        cnt_nx = cnt_r + CNT_ONE;
      end
    end else if (state_r == ST_NIGHT) begin
      state_nx = ST_MG;
      rem_nx   = DUR_MG;
      cnt_nx   = CNT_ZERO;
      flash_nx = 1'b0;
    end else if (hold) begin
      cnt_nx = cnt_r;
    end else if (tick_s) begin
      cnt_nx = CNT_ZERO;
      if (rem_r > 7'd1) begin
        rem_nx = rem_r - 7'd1;
      end else begin
        state_nx = next_phase(state_r);
        rem_nx   = phase_dur(next_phase(state_r));
      end
    end else begin
      cnt_nx = cnt_r + CNT_ONE;
    end
  end

  // State, timer, divider and output registers; outputs update on the same edge.
  always_ff @(posedge CLK1K or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_MG;
      rem_r   <= DUR_MG;
      cnt_r   <= CNT_ZERO;
      flash_r <= 1'b0;
      disp_r  <= decode(ST_MG, DUR_MG, 1'b0);
    end else begin
      state_r <= state_nx;
      rem_r   <= rem_nx;
      cnt_r   <= cnt_nx;
      flash_r <= flash_nx;
      disp_r  <= decode(state_nx, rem_nx, flash_nx);
    end
  end

  assign lamp_m = disp_r.lm;
  assign lamp_s = disp_r.ls;
  assign num_1  = disp_r.n1;
  assign num_2  = disp_r.n2;
  assign num_3  = disp_r.n3;
  assign num_4  = disp_r.n4;
  assign num_5  = BLANK;
  assign num_6  = disp_r.n6;

endmodule

// File: tb/tb_traffic_ctrl.sv
// Bench for traffic_ctrl with a fast divider and short phases.
module tb_traffic_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hold = 1'b0;
  logic       night = 1'b0;
  logic [2:0] lamp_m, lamp_s;
  logic [3:0] num_1, num_2, num_3, num_4, num_5, num_6;
  logic [29:0] dut_vec;

  traffic_ctrl #(.TICK_DIV(4), .T_MG(5), .T_SG(4), .T_Y(2)) dut (
    .CLK1K(clk), .rst_n(rst_n), .hold(hold), .night(night),
    .lamp_m(lamp_m), .lamp_s(lamp_s),
    .num_1(num_1), .num_2(num_2), .num_3(num_3),
    .num_4(num_4), .num_5(num_5), .num_6(num_6)
  );

  always #5 clk = ~clk;

  assign dut_vec = {lamp_m, lamp_s, num_1, num_2, num_3, num_4, num_5, num_6};

  int          tests = 0;
  int          fails = 0;
  logic [29:0] sb[$];
  logic [29:0] want;

  // Reference model: phase 0 = night, 1..4 = MG, MY, SG, SY.
  int   m_phase, m_rem, m_cnt;
  logic m_flash;

  function automatic int dur(input int p);
    case (p)
      1: return 5;
      2: return 2;
      3: return 4;
      4: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [29:0] model_vec();
    logic [2:0] lm, ls;
    logic [3:0] n1, n2, n3, n4, n6;
    int mv, sv;
    lm = 3'b000; ls = 3'b000; mv = m_rem; sv = m_rem;
    case (m_phase)
      1: begin lm = 3'b001; ls = 3'b100; sv = m_rem + 2; end
      2: begin lm = 3'b010; ls = 3'b100; end
      3: begin lm = 3'b100; ls = 3'b001; mv = m_rem + 2; end
      4: begin lm = 3'b100; ls = 3'b010; end
      default: begin lm = {1'b0, m_flash, 1'b0}; ls = lm; end
    endcase
    if (m_phase == 0) begin
      n1 = 4'hA; n2 = 4'hA; n3 = 4'hA; n4 = 4'hA; n6 = 4'hA;
    end else begin
      n1 = 4'(mv % 10); n2 = 4'(mv / 10);
      n3 = 4'(sv % 10); n4 = 4'(sv / 10);
      n6 = 4'(m_phase);
    end
    return {lm, ls, n1, n2, n3, n4, 4'hA, n6};
  endfunction

  task automatic model_reset();
    m_phase = 1; m_rem = 5; m_cnt = 0; m_flash = 1'b0;
    sb.delete();
  endtask

  task automatic model_edge();
    if (night) begin
      if (m_phase != 0) begin
        m_phase = 0; m_cnt = 0; m_flash = 1'b0;
      end else if (m_cnt == 3) begin
        m_cnt = 0; m_flash = ~m_flash;
      end else begin
        m_cnt++;
      end
    end else if (m_phase == 0) begin
      m_phase = 1; m_rem = 5; m_cnt = 0; m_flash = 1'b0;
    end else if (!hold) begin
      if (m_cnt == 3) begin
        m_cnt = 0;
        if (m_rem > 1) m_rem--;
        else begin
          m_phase = (m_phase == 4) ? 1 : m_phase + 1;
          m_rem   = dur(m_phase);
        end
      end else begin
        m_cnt++;
      end
    end
  endtask

  // One clock: predict, enqueue, advance, sample 1 time unit after the edge.
  task automatic step();
    model_edge();
    sb.push_back(model_vec());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hold = 1'b0; night = 1'b0;
    model_reset();
    #12;
    tests++; if (lamp_m !== 3'b001) begin fails++; $display("FAIL reset_lamp_m got %b want 001", lamp_m); end
    tests++; if (lamp_s !== 3'b100) begin fails++; $display("FAIL reset_lamp_s got %b want 100", lamp_s); end
    tests++; if ({num_2, num_1} !== {4'd0, 4'd5}) begin fails++; $display("FAIL reset_main got %h%h want 05", num_2, num_1); end
    tests++; if ({num_4, num_3} !== {4'd0, 4'd7}) begin fails++; $display("FAIL reset_side got %h%h want 07", num_4, num_3); end
    tests++; if ({num_5, num_6} !== {4'hA, 4'd1}) begin fails++; $display("FAIL reset_n56 got %h%h want A1", num_5, num_6); end
    rst_n = 1'b1;
  endtask

  task automatic test_sequence();
    logic [3:0] prev;
    prev = num_1;
    for (int i = 0; i < 28; i++) begin
      step();
      want = sb.pop_front();
      tests++; if (dut_vec !== want) begin fails++; $display("FAIL seq[%0d] got %h want %h", i, dut_vec, want); end
      if (i < 20) begin
        tests++;
        if ((num_1 !== prev) !== (i % 4 == 3)) begin
          fails++; $display("FAIL tick_period[%0d] got digit %h after %h, tick expected=%0d", i, num_1, prev, (i % 4 == 3));
        end
      end
      prev = num_1;
      if (i == 19) begin
        tests++;
        if ({lamp_m, num_6, num_2, num_1, num_4, num_3} !== {3'b010, 4'd2, 4'd0, 4'd2, 4'd0, 4'd2}) begin
          fails++; $display("FAIL enter_my got lamp %b ph %h main %h%h side %h%h want 010 2 02 02", lamp_m, num_6, num_2, num_1, num_4, num_3);
        end
      end
    end
    tests++;
    if ({lamp_s, num_6, num_2, num_1, num_4, num_3} !== {3'b001, 4'd3, 4'd0, 4'd6, 4'd0, 4'd4}) begin
      fails++; $display("FAIL enter_sg got lamp_s %b ph %h main %h%h side %h%h want 001 3 06 04", lamp_s, num_6, num_2, num_1, num_4, num_3);
    end
  endtask

  task automatic test_full_cycle();
    int seq[$];
    int exp_seq[5];
    exp_seq = '{1, 2, 3, 4, 1};
    rst_n = 1'b0; #2; rst_n = 1'b1;
    model_reset();
    seq.push_back(int'(num_6));
    for (int i = 0; i < 52; i++) begin
      step();
      want = sb.pop_front();
      tests++; if (dut_vec !== want) begin fails++; $display("FAIL cycle[%0d] got %h want %h", i, dut_vec, want); end
      tests++; if (!($onehot(lamp_m) && $onehot(lamp_s))) begin fails++; $display("FAIL onehot[%0d] got %b/%b want one-hot", i, lamp_m, lamp_s); end
      if (int'(num_6) != seq[$]) seq.push_back(int'(num_6));
    end
    tests++; if (seq.size() != 5) begin fails++; $display("FAIL phase_count got %0d want 5", seq.size()); end
    for (int k = 0; k < 5 && k < seq.size(); k++) begin
      tests++; if (seq[k] != exp_seq[k]) begin fails++; $display("FAIL phase_seq[%0d] got %0d want %0d", k, seq[k], exp_seq[k]); end
    end
    tests++; if ({num_6, num_2, num_1} !== {4'd1, 4'd0, 4'd5}) begin fails++; $display("FAIL cycle_end got ph %h main %h%h want 1 05", num_6, num_2, num_1); end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 9; i++) begin
      step();
      want = sb.pop_front();
      tests++; if (dut_vec !== want) begin fails++; $display("FAIL pre_hold[%0d] got %h want %h", i, dut_vec, want); end
    end
    tests++; if (num_1 !== 4'd3) begin fails++; $display("FAIL hold_start got %h want 3", num_1); end
    hold = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      want = sb.pop_front();
      tests++; if (dut_vec !== want || num_1 !== 4'd3) begin fails++; $display("FAIL hold[%0d] got %h want %h", i, dut_vec, want); end
    end
    hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      want = sb.pop_front();
      tests++; if (dut_vec !== want) begin fails++; $display("FAIL release[%0d] got %h want %h", i, dut_vec, want); end
      tests++;
      if (num_1 !== ((i == 2) ? 4'd2 : 4'd3)) begin
        fails++; $display("FAIL release_tick[%0d] got %h want %h", i, num_1, (i == 2) ? 4'd2 : 4'd3);
      end
    end
  endtask

  task automatic test_night();
    int guard = 0;
    while (m_phase != 4 && guard < 100) begin
      step();
      want = sb.pop_front();
      tests++; if (dut_vec !== want) begin fails++; $display("FAIL to_sy[%0d] got %h want %h", guard, dut_vec, want); end
      guard++;
    end
    tests++; if (lamp_s !== 3'b010) begin fails++; $display("FAIL reach_sy got lamp_s %b want 010", lamp_s); end
    night = 1'b1; hold = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      want = sb.pop_front();
      tests++; if (dut_vec !== want) begin fails++; $display("FAIL night[%0d] got %h want %h", i, dut_vec, want); end
      tests++;
      if (lamp_m !== ((i >= 4 && i < 8) ? 3'b010 : 3'b000) || lamp_s !== lamp_m || {num_1, num_4, num_6} !== 12'hAAA) begin
        fails++; $display("FAIL night_flash[%0d] got %b/%b digits %h%h%h", i, lamp_m, lamp_s, num_1, num_4, num_6);
      end
    end
    night = 1'b0; hold = 1'b0;
    step();
    want = sb.pop_front();
    tests++; if (dut_vec !== want) begin fails++; $display("FAIL night_exit got %h want %h", dut_vec, want); end
    tests++;
    if ({lamp_m, lamp_s, num_2, num_1} !== {3'b001, 3'b100, 4'd0, 4'd5}) begin
      fails++; $display("FAIL night_exit_mg got %b/%b main %h%h want 001/100 05", lamp_m, lamp_s, num_2, num_1);
    end
  endtask

  task automatic test_async_reset();
    int guard = 0;
    while (m_phase != 3 && guard < 100) begin
      step();
      want = sb.pop_front();
      tests++; if (dut_vec !== want) begin fails++; $display("FAIL to_sg[%0d] got %h want %h", guard, dut_vec, want); end
      guard++;
    end
    #2; rst_n = 1'b0; #1;
    tests++;
    if ({lamp_m, lamp_s, num_1, num_3, num_6} !== {3'b001, 3'b100, 4'd5, 4'd7, 4'd1}) begin
      fails++; $display("FAIL async_reset got %b/%b %h %h %h want 001/100 5 7 1", lamp_m, lamp_s, num_1, num_3, num_6);
    end
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 24; i++) begin
      step();
      want = sb.pop_front();
      tests++; if (dut_vec !== want) begin fails++; $display("FAIL post_reset[%0d] got %h want %h", i, dut_vec, want); end
    end
    tests++; if (num_6 !== 4'd2) begin fails++; $display("FAIL post_reset_phase got %h want 2", num_6); end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_full_cycle();
    test_hold();
    test_night();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
